// File: rtl/rf_pkg.sv
// Shared constants and types for the multiport register file.
// Defaults match the reference datapath configuration.
package rf_pkg;
    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NREAD_DEF    = 2;
    localparam int LINK_REG_DEF = 31;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the register file.
// Tracks claimed-but-unwritten registers and decodes per-port busy.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_W-1:0]       rw_i,
    input  logic                    link_wr_i,
    input  logic                    claim_en_i,
    input  logic [ADDR_W-1:0]       claim_reg_i,
    input  logic [NREAD*ADDR_W-1:0] ra_i,
    output logic [NREAD-1:0]        busy_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;

    // Clears are applied first so a same-cycle claim (newer producer) wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_i) begin
            pending_d[rw_i] = 1'b0;
        end
        if (link_wr_i) begin
            pending_d[LINK_IDX] = 1'b0;
        end
        if (claim_en_i && claim_reg_i != '0) begin
            pending_d[claim_reg_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_busy
        logic [ADDR_W-1:0] ra;
        logic              hit;
        assign ra  = ra_i[g*ADDR_W +: ADDR_W];
        assign hit = (wr_en_i && rw_i == ra)
                   || (link_wr_i && ra == LINK_IDX);
        assign busy_o[g] = pending_q[ra] & ~hit & (ra != '0);
    end
endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: NREAD bypassed read ports, writeback and
// link write sources, pending-write scoreboard and a debug read port.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    WrEn,
    input  logic [ADDR_W-1:0]       Rw,
    input  logic [DATA_W-1:0]       busW,
    input  logic                    LinkWr,
    input  logic [DATA_W-3:0]       LinkPC,
    input  logic [NREAD*ADDR_W-1:0] Ra,
    output logic [NREAD*DATA_W-1:0] busR,
    output logic [NREAD-1:0]        busy,
    input  logic                    ClaimEn,
    input  logic [ADDR_W-1:0]       ClaimReg,
    input  logic [ADDR_W-1:0]       rf_addr,
    output logic [DATA_W-1:0]       rf_data
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] link_word;

    assign link_word = {LinkPC, 2'b00};

    // Link write is issued last so it wins a collision with writeback.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (WrEn && Rw != '0) begin
                regs_q[Rw] <= busW;
            end
            if (LinkWr && LINK_IDX != '0) begin
                regs_q[LINK_IDX] <= link_word;
            end
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        assign ra = Ra[g*ADDR_W +: ADDR_W];
        always_comb begin
            rd = regs_q[ra];
            if (ra == '0) begin
                rd = '0;
            end else if (LinkWr && ra == LINK_IDX) begin
                rd = link_word;
            end else if (WrEn && ra == Rw) begin
                rd = busW;
            end
        end
        assign busR[g*DATA_W +: DATA_W] = rd;
    end

    assign rf_data = (rf_addr == '0) ? '0 : regs_q[rf_addr];

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NREAD    (NREAD),
        .LINK_REG (LINK_REG)
    ) u_sb (
        .clk_i       (Clk),
        .reset_i     (Reset),
        .wr_en_i     (WrEn),
        .rw_i        (Rw),
        .link_wr_i   (LinkWr),
        .claim_en_i  (ClaimEn),
        .claim_reg_i (ClaimReg),
        .ra_i        (Ra),
        .busy_o      (busy)
    );
endmodule
